// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx
// SPI slave receiver (mode 0, MSB first) that sits in front of the low-res
// line buffer. sclk, mosi and cs_n are oversampled in the CLK domain. Each
// accepted pixel comes out as a 9-bit word together with a stretched strobe.
//
// Ports:
//   CLK          in   system clock
//   reset        in   synchronous, active-high reset
//   sclk         in   SPI clock (asynchronous)
//   mosi         in   SPI data (asynchronous)
//   cs_n         in   SPI chip select, active low (asynchronous)
//   Data         out  {sof, pixel[7:0]}; valid from the rising edge of clk_SPI
//   clk_SPI      out  pixel strobe: one pulse per pixel
//   frame_err    out  sticky error flag; cleared by reset or a valid SOF header
//   pixel_count  out  pixels accepted since the last SOF; saturates at FRAME_PIXELS
module spi_pixel_rx #(
  parameter int          SYNC_STAGES  = 2,
  parameter int          STROBE_HIGH  = 2,
  parameter int          STROBE_GAP   = 2,
  parameter int          FRAME_PIXELS = 1200,
  parameter logic [7:0]  HDR_SOF      = 8'hA5,
  parameter logic [7:0]  HDR_CONT     = 8'h5A
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic [8:0]  Data,
  output logic        clk_SPI,
  output logic        frame_err,
  output logic [10:0] pixel_count
);

  localparam int CNT_MAX = (STROBE_HIGH > STROBE_GAP) ? STROBE_HIGH : STROBE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_C       = CNT_W'(STROBE_GAP);
  localparam logic [CNT_W-1:0] HIGH_LAST_C = CNT_W'(STROBE_HIGH - 1);
  localparam logic [10:0]      FRAME_C     = 11'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HDR  = 2'd1,
    RX_PIX  = 2'd2,
    RX_DROP = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2
  } st_state_t;

  // Synchroniser chains; the last stage is the usable, metastability-free copy.
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_prev_r;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise_s;

  // Receive state.
  rx_state_t   rx_state_r, rx_nx_s;
  logic [2:0]  bit_cnt_r, bit_cnt_nx_s;
  logic [6:0]  shift_r, shift_nx_s;
  logic        sof_pending_r, sof_pending_nx_s;
  logic        sof_seen_r, sof_seen_nx_s;
  logic [10:0] pixel_count_nx_s;
  logic        frame_err_nx_s;
  logic        hold_full_r, hold_full_nx_s;
  logic [8:0]  hold_data_r, hold_data_nx_s;
  logic [7:0]  byte_s;

  // Strobe state.
  st_state_t        st_r, st_nx_s;
  logic [CNT_W-1:0] st_cnt_r, st_cnt_nx_s;
  logic             drain_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  // Byte as it would stand once the current synced mosi bit is shifted in.
  assign byte_s      = {shift_r, mosi_s};

  // Synchronise the SPI inputs and keep sclk history for edge detection.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_prev_r <= sclk_s;
    end
  end

  // Strobe machine: LOW waits for a full holding register and a rested gap,
  // SETUP presents Data one cycle ahead of the rise, HIGH stretches the pulse.
  always_comb begin
    st_nx_s     = st_r;
    st_cnt_nx_s = st_cnt_r;
    drain_s     = 1'b0;
    case (st_r)
      ST_LOW: begin
        if (hold_full_r && (st_cnt_r >= GAP_C)) begin
          st_nx_s     = ST_SETUP;
          st_cnt_nx_s = {CNT_W{1'b0}};
          drain_s     = 1'b1;
        end else if (st_cnt_r < GAP_C) begin
          st_cnt_nx_s = st_cnt_r + CNT_W'(1);
        end else begin
          st_cnt_nx_s = st_cnt_r;
        end
      end
      ST_SETUP: begin
        st_nx_s     = ST_HIGH;
        st_cnt_nx_s = {CNT_W{1'b0}};
      end
      ST_HIGH: begin
        if (st_cnt_r == HIGH_LAST_C) begin
          st_nx_s     = ST_LOW;
          st_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
          st_cnt_nx_s = st_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        st_nx_s     = ST_LOW;
        st_cnt_nx_s = GAP_C;
      end
    endcase
  end

  // Receive machine: bit assembly, header decode, pixel acceptance and the
  // holding register load. cs_n high wins over a byte completing together.
  always_comb begin
    rx_nx_s          = rx_state_r;
    bit_cnt_nx_s     = bit_cnt_r;
    shift_nx_s       = shift_r;
    sof_pending_nx_s = sof_pending_r;
    sof_seen_nx_s    = sof_seen_r;
    pixel_count_nx_s = pixel_count;
    frame_err_nx_s   = frame_err;
    hold_data_nx_s   = hold_data_r;
    // A drain this cycle frees the register; a load below may refill it.
    if (drain_s) begin
      hold_full_nx_s = 1'b0;
    end else begin
      hold_full_nx_s = hold_full_r;
    end

    if (cs_s) begin
      rx_nx_s      = RX_IDLE;
      bit_cnt_nx_s = 3'd0;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          rx_nx_s      = RX_HDR;
          bit_cnt_nx_s = 3'd0;
        end
        RX_HDR, RX_PIX: begin
          if (sclk_rise_s) begin
            shift_nx_s   = byte_s[6:0];
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (rx_state_r == RX_HDR) begin
                if (byte_s == HDR_SOF) begin
                  sof_pending_nx_s = 1'b1;
                  sof_seen_nx_s    = 1'b1;
                  pixel_count_nx_s = 11'd0;
                  frame_err_nx_s   = 1'b0;
                  rx_nx_s          = RX_PIX;
                end else if ((byte_s == HDR_CONT) && sof_seen_r) begin
                  rx_nx_s = RX_PIX;
                end else begin
                  frame_err_nx_s = 1'b1;
                  rx_nx_s        = RX_DROP;
                end
              end else if (pixel_count < FRAME_C) begin
                // Accepted from SPI; counted even if the overrun drops it.
                pixel_count_nx_s = pixel_count + 11'd1;
                if (hold_full_r && !drain_s) begin
                  frame_err_nx_s = 1'b1;
                end else begin
                  hold_full_nx_s   = 1'b1;
                  hold_data_nx_s   = {sof_pending_r, byte_s};
                  sof_pending_nx_s = 1'b0;
                end
              end else begin
                frame_err_nx_s = 1'b1;
              end
            end else begin
              rx_nx_s = rx_state_r;
            end
          end else begin
            rx_nx_s = rx_state_r;
          end
        end
        RX_DROP: begin
          rx_nx_s = RX_DROP;
        end
        default: begin
          rx_nx_s      = RX_IDLE;
          bit_cnt_nx_s = 3'd0;
        end
      endcase
    end
  end

  // State and output registers; Data changes only on entry to SETUP.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_state_r    <= RX_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 7'd0;
      sof_pending_r <= 1'b0;
      sof_seen_r    <= 1'b0;
      pixel_count   <= 11'd0;
      frame_err     <= 1'b0;
      hold_full_r   <= 1'b0;
      hold_data_r   <= 9'd0;
      st_r          <= ST_LOW;
      st_cnt_r      <= GAP_C;
      Data          <= 9'd0;
      clk_SPI       <= 1'b0;
    end else begin
      rx_state_r    <= rx_nx_s;
      bit_cnt_r     <= bit_cnt_nx_s;
      shift_r       <= shift_nx_s;
      sof_pending_r <= sof_pending_nx_s;
      sof_seen_r    <= sof_seen_nx_s;
      pixel_count   <= pixel_count_nx_s;
      frame_err     <= frame_err_nx_s;
      hold_full_r   <= hold_full_nx_s;
      hold_data_r   <= hold_data_nx_s;
      st_r          <= st_nx_s;
      st_cnt_r      <= st_cnt_nx_s;
      if (drain_s) begin
        Data <= hold_data_r;
      end
      clk_SPI <= (st_nx_s == ST_HIGH);
    end
  end

endmodule

// File: tb/tb_spi_pixel_rx.sv
module tb_spi_pixel_rx;

  logic        CLK = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [8:0]  Data, Data2;
  logic        clk_SPI, clk_SPI2;
  logic        frame_err, frame_err2;
  logic [10:0] pixel_count, pixel_count2;

  int total = 0;
  int bad = 0;

  // Scoreboard of expected Data words for the default instance.
  logic [8:0] exp_q[$];
  int strobes = 0;
  int strobes2 = 0;

  // Reference model of framing state.
  logic m_seen, m_pend, m_pix, m_err;
  int   m_count;

  spi_pixel_rx u_dut (
    .CLK(CLK), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .Data(Data), .clk_SPI(clk_SPI), .frame_err(frame_err), .pixel_count(pixel_count)
  );

  // The default strobe completes well inside one byte time, so a
  // slow-strobe instance is used to make a holding-register overrun occur.
  spi_pixel_rx #(.STROBE_HIGH(20), .STROBE_GAP(16)) u_dut_slow (
    .CLK(CLK), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .Data(Data2), .clk_SPI(clk_SPI2), .frame_err(frame_err2), .pixel_count(pixel_count2)
  );

  always #5 CLK = ~CLK;

  // Strobe monitor: scoreboard pop plus pulse-shape checks, sampled 1 after posedge.
  initial begin
    logic       prev_clk, prev_clk2;
    logic [8:0] prev_data, rise_data, exp_v;
    int         high_len, low_len;
    prev_clk = 1'b0; prev_clk2 = 1'b0; prev_data = 9'd0; rise_data = 9'd0;
    high_len = 0; low_len = 0;
    forever begin
      @(posedge CLK); #1;
      if (reset === 1'b1) begin
        prev_clk = 1'b0; prev_clk2 = 1'b0; high_len = 0; low_len = 0; prev_data = Data;
      end else begin
        if (clk_SPI2 && !prev_clk2) strobes2++;
        prev_clk2 = clk_SPI2;
        if (clk_SPI && !prev_clk) begin
          strobes++;
          total++;
          if (low_len < 2) begin
            bad++; $display("FAIL strobe_gap: low for %0d cycles, want >= 2", low_len);
          end
          total++;
          if (Data !== prev_data) begin
            bad++; $display("FAIL data_setup: Data %h at rise, %h one cycle before", Data, prev_data);
          end
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_strobe: Data=%h, no strobe expected", Data);
          end else begin
            exp_v = exp_q.pop_front();
            total++;
            if (Data !== exp_v) begin
              bad++; $display("FAIL strobe_data: got %h want %h", Data, exp_v);
            end
          end
          high_len = 1; rise_data = Data;
        end else if (clk_SPI) begin
          high_len++;
        end else if (prev_clk) begin
          total++;
          if (high_len != 2) begin
            bad++; $display("FAIL strobe_high: high for %0d cycles, want 2", high_len);
          end
          total++;
          if (Data !== rise_data) begin
            bad++; $display("FAIL data_hold: Data %h at fall, %h at rise", Data, rise_data);
          end
          low_len = 1;
        end else begin
          low_len++;
        end
        prev_clk = clk_SPI; prev_data = Data;
      end
    end
  end

  task automatic model_reset();
    m_seen = 1'b0; m_pend = 1'b0; m_pix = 1'b0; m_err = 1'b0; m_count = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  // Shift out the top nbits of b; each bit is 2*hp CLK cycles long.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input int hp);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i]; sclk = 1'b0;
      repeat (hp) @(negedge CLK);
      sclk = 1'b1;
      repeat (hp) @(negedge CLK);
    end
  endtask

  task automatic cs_begin();
    @(negedge CLK);
    sclk = 1'b0; cs_n = 1'b0; m_pix = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic cs_end();
    repeat (3) @(negedge CLK);
    sclk = 1'b0; cs_n = 1'b1; m_pix = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic send_hdr(input logic [7:0] b, input int hp);
    if (b == 8'hA5) begin
      m_pend = 1'b1; m_seen = 1'b1; m_count = 0; m_err = 1'b0; m_pix = 1'b1;
    end else if (b == 8'h5A && m_seen) begin
      m_pix = 1'b1;
    end else begin
      m_err = 1'b1; m_pix = 1'b0;
    end
    spi_bits(b, 8, hp);
  endtask

  task automatic send_pix(input logic [7:0] b, input int hp);
    if (m_pix) begin
      if (m_count < 1200) begin
        exp_q.push_back({m_pend, b});
        m_pend = 1'b0; m_count++;
      end else begin
        m_err = 1'b1;
      end
    end
    spi_bits(b, 8, hp);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge CLK); n++;
    end
    repeat (12) @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain: %0d strobes outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (Data !== 9'd0) begin bad++; $display("FAIL reset_data: got %h want 000", Data); end
    total++; if (clk_SPI !== 1'b0) begin bad++; $display("FAIL reset_clk: got %b want 0", clk_SPI); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
    total++; if (pixel_count !== 11'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", pixel_count); end
  endtask

  task automatic test_sof();
    int s0;
    s0 = strobes;
    cs_begin();
    send_hdr(8'hA5, 2);
    send_pix(8'h11, 2); send_pix(8'h22, 2); send_pix(8'h33, 2);
    cs_end();
    wait_drain();
    total++; if (strobes - s0 != 3) begin bad++; $display("FAIL sof_strobes: got %0d want 3", strobes - s0); end
    total++; if (pixel_count !== 11'd3) begin bad++; $display("FAIL sof_count: got %0d want 3", pixel_count); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL sof_err: got %b want 0", frame_err); end
  endtask

  task automatic test_continuation();
    int s0;
    s0 = strobes;
    cs_begin();
    send_hdr(8'h5A, 2); send_pix(8'h44, 2);
    cs_end();
    wait_drain();
    total++; if (strobes - s0 != 1) begin bad++; $display("FAIL cont_strobes: got %0d want 1", strobes - s0); end
    total++; if (Data !== 9'h044) begin bad++; $display("FAIL cont_data: got %h want 044", Data); end
    total++; if (pixel_count !== 11'd4) begin bad++; $display("FAIL cont_count: got %0d want 4", pixel_count); end
  endtask

  task automatic test_bad_header();
    int s0;
    do_reset();
    s0 = strobes;
    cs_begin();
    send_hdr(8'h5A, 2); send_pix(8'h77, 2);
    cs_end();
    wait_drain();
    total++; if (strobes - s0 != 0) begin bad++; $display("FAIL bad_hdr_strobes: got %0d want 0", strobes - s0); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL bad_hdr_err: got %b want 1", frame_err); end
    cs_begin();
    send_hdr(8'hA5, 2); send_pix(8'h01, 2);
    cs_end();
    wait_drain();
    total++; if (Data !== 9'h101) begin bad++; $display("FAIL resync_data: got %h want 101", Data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_err: got %b want 0", frame_err); end
  endtask

  task automatic test_abort();
    int s0;
    s0 = strobes;
    cs_begin();
    send_hdr(8'hA5, 2);
    spi_bits(8'hFF, 5, 2);
    cs_end();
    repeat (20) @(negedge CLK);
    total++; if (strobes - s0 != 0) begin bad++; $display("FAIL abort_strobes: got %0d want 0", strobes - s0); end
    total++; if (pixel_count !== 11'd0) begin bad++; $display("FAIL abort_count: got %0d want 0", pixel_count); end
    // The SOF flag survives the abort and lands on the next pixel.
    cs_begin();
    send_hdr(8'h5A, 2); send_pix(8'h66, 2);
    cs_end();
    wait_drain();
    total++; if (Data !== 9'h166) begin bad++; $display("FAIL after_abort_data: got %h want 166", Data); end
    total++; if (pixel_count !== 11'd1) begin bad++; $display("FAIL after_abort_count: got %0d want 1", pixel_count); end
  endtask

  task automatic test_back_to_back();
    int s0, s2;
    do_reset();
    s0 = strobes; s2 = strobes2;
    cs_begin();
    send_hdr(8'hA5, 1);
    send_pix(8'h81, 1); send_pix(8'h82, 1); send_pix(8'h83, 1);
    cs_end();
    wait_drain();
    repeat (120) @(negedge CLK);
    total++; if (strobes - s0 != 3) begin bad++; $display("FAIL b2b_strobes: got %0d want 3", strobes - s0); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", frame_err); end
    total++; if (strobes2 - s2 != 2) begin bad++; $display("FAIL ovr_strobes: got %0d want 2", strobes2 - s2); end
    total++; if (frame_err2 !== 1'b1) begin bad++; $display("FAIL ovr_err: got %b want 1", frame_err2); end
    total++; if (pixel_count2 !== 11'd3) begin bad++; $display("FAIL ovr_count: got %0d want 3", pixel_count2); end
    total++; if (Data2 !== 9'h082) begin bad++; $display("FAIL ovr_data: got %h want 082", Data2); end
  endtask

  task automatic test_overflow();
    int s0;
    do_reset();
    s0 = strobes;
    cs_begin();
    send_hdr(8'hA5, 1);
    for (int i = 0; i < 1201; i++) send_pix(8'(i * 7 + 3), 1);
    cs_end();
    wait_drain();
    total++; if (strobes - s0 != 1200) begin bad++; $display("FAIL ovf_strobes: got %0d want 1200", strobes - s0); end
    total++; if (pixel_count !== 11'd1200) begin bad++; $display("FAIL ovf_count: got %0d want 1200", pixel_count); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", frame_err); end
  endtask

  task automatic test_reset_high();
    int n, s0;
    do_reset();
    s0 = strobes;
    cs_begin();
    send_hdr(8'hA5, 2); send_pix(8'h99, 2);
    n = 0;
    while (clk_SPI !== 1'b1 && n < 50) begin
      @(negedge CLK); n++;
    end
    total++;
    if (clk_SPI !== 1'b1) begin
      bad++; $display("FAIL rst_high_wait: clk_SPI=%b, want 1 within 50 cycles", clk_SPI);
    end
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0;
    @(posedge CLK); #1;
    total++; if (clk_SPI !== 1'b0) begin bad++; $display("FAIL rst_high_clk: got %b want 0", clk_SPI); end
    total++; if (Data !== 9'd0) begin bad++; $display("FAIL rst_high_data: got %h want 000", Data); end
    total++; if (pixel_count !== 11'd0) begin bad++; $display("FAIL rst_high_count: got %0d want 0", pixel_count); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_high_err: got %b want 0", frame_err); end
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    repeat (20) @(negedge CLK);
    total++; if (strobes - s0 != 1) begin bad++; $display("FAIL rst_high_strobes: got %0d want 1", strobes - s0); end
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    model_reset();
    test_reset();
    test_sof();
    test_continuation();
    test_bad_header();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_reset_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
